// File: rtl/router_reg_pkg.sv
// Shared types and constants for the router byte datapath and its control FSM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package router_reg_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  // Destination 3 does not exist on a 1x3 router.
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef logic [DATA_W-1:0] byte_t;

  // Control FSM state encodings; this block only sees their one-hot decodes.
  typedef enum logic [2:0] {
    DECODER_ADDRESS    = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_PARITY        = 3'd4,
    CHECK_PARITY_ERROR = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    LOAD_AFTER_FULL    = 3'd7
  } fsm_state_e;

  // True when the header byte addresses a real output port.
  function automatic logic addr_ok(input byte_t hdr);
    return hdr[ADDR_W-1:0] != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_reg_if.sv
// Bundle between the control FSM / input port and the byte register stage.
// Latency: n/a (wires only).
// Backpressure: fifo_full is the only stall input; no ready signal back to the source.
interface router_reg_if;
  import router_reg_pkg::*;

  logic  pkt_valid;
  byte_t data_in;
  logic  fifo_full;
  logic  detect_add;
  logic  lfd_state;
  logic  ld_state;
  logic  full_state;
  logic  laf_state;
  logic  rst_int_reg;
  byte_t dout;
  logic  parity_done;
  logic  low_pkt_valid;
  logic  err;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );

endinterface

// File: rtl/router_reg_parity_acc.sv
// Running XOR of the packet bytes, captured parity byte, and mismatch flag.
// Latency: err valid one edge after the compare cycle.
// Backpressure: none; enables come straight from the FSM decodes.
module router_reg_parity_acc
  import router_reg_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  acc_en_i,
  input  byte_t acc_dat_i,
  input  logic  pkt_ld_i,
  input  byte_t pkt_dat_i,
  input  logic  cmp_i,
  input  logic  err_clr_i,
  output logic  err_o
);

  byte_t int_parity_q, int_parity_d;
  byte_t pkt_parity_q, pkt_parity_d;
  logic  err_q, err_d;

  // Next-state for accumulator, captured parity and error flag.
  always_comb begin
    int_parity_d = int_parity_q;
    pkt_parity_d = pkt_parity_q;
    err_d        = err_q;

    if (clr_i)
      int_parity_d = '0;
    else if (acc_en_i)
      int_parity_d = int_parity_q ^ acc_dat_i;

    if (pkt_ld_i)
      pkt_parity_d = pkt_dat_i;

    if (cmp_i)
      err_d = (int_parity_q != pkt_parity_q);
    else if (err_clr_i)
      err_d = 1'b0;
  end

  // Parity state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_parity_q <= '0;
      pkt_parity_q <= '0;
      err_q        <= 1'b0;
    end else begin
      int_parity_q <= int_parity_d;
      pkt_parity_q <= pkt_parity_d;
      err_q        <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/router_reg.sv
// Router byte register stage: header capture, dout drive, full-stall hold byte, parity check.
// Latency: one cycle from data_in to dout; err one cycle after rst_int_reg.
// Backpressure: on fifo_full the in-flight byte parks in hold_reg and replays in laf_state.
module router_reg
  import router_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  router_reg_if.slave bus
);

  byte_t dout_q, dout_d;
  byte_t header_q, header_d;
  byte_t hold_q, hold_d;
  logic  parity_done_q, parity_done_d;
  logic  low_pkt_valid_q, low_pkt_valid_d;

  logic  acc_en;
  byte_t acc_dat;
  logic  last_byte;

  // The parity byte is the ld_state byte that arrives with pkt_valid low.
  assign last_byte = bus.ld_state && !bus.pkt_valid;

  // Next-state for header, output byte, hold byte and end-of-packet flags.
  always_comb begin
    header_d        = header_q;
    dout_d          = dout_q;
    hold_d          = hold_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;

    if (bus.detect_add && bus.pkt_valid && addr_ok(bus.data_in))
      header_d = bus.data_in;

    if (bus.lfd_state)
      dout_d = header_q;
    else if (bus.ld_state && !bus.fifo_full)
      dout_d = bus.data_in;
    else if (bus.ld_state && bus.fifo_full)
      hold_d = bus.data_in;
    else if (bus.laf_state)
      dout_d = hold_q;
    else if (bus.full_state)
      dout_d = dout_q;

    if (last_byte)
      low_pkt_valid_d = 1'b1;
    else if (bus.rst_int_reg || bus.detect_add)
      low_pkt_valid_d = 1'b0;

    // Second set term covers a parity byte that was parked in hold_reg.
    if ((last_byte && !bus.fifo_full) ||
        (bus.laf_state && low_pkt_valid_q && !parity_done_q))
      parity_done_d = 1'b1;
    else if (bus.detect_add)
      parity_done_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q          <= '0;
      header_q        <= '0;
      hold_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      dout_q          <= dout_d;
      header_q        <= header_d;
      hold_q          <= hold_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
    end
  end

  // Held bytes were already counted when they were consumed in ld_state.
  assign acc_en  = bus.lfd_state || (bus.ld_state && bus.pkt_valid);
  assign acc_dat = bus.lfd_state ? header_q : bus.data_in;

  router_reg_parity_acc u_parity (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (bus.detect_add),
    .acc_en_i  (acc_en),
    .acc_dat_i (acc_dat),
    .pkt_ld_i  (last_byte),
    .pkt_dat_i (bus.data_in),
    .cmp_i     (bus.rst_int_reg),
    .err_clr_i (bus.detect_add && bus.pkt_valid),
    .err_o     (bus.err)
  );

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Byte datapath register stage of the 1x3 router, sitting between the input port and the three output FIFOs.
- Driven by the router control FSM's state decodes (detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg).
- Captures the header byte, drives dout, and holds one byte across a FIFO-full stall.
- Accumulates internal parity and compares it with the packet parity byte.
- Returns parity_done, low_pkt_valid and err to the FSM and to the top level.

Parameters:
- DATA_W, 8, byte width of data_in/dout/parity registers.
- ADDR_W, 2, width of the destination address field in header bits [ADDR_W-1:0].

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pkt_valid  input  1  high while header/payload bytes are on data_in; low on the parity byte.
- data_in  input  DATA_W  packet byte stream.
- fifo_full  input  1  full flag of the currently addressed output FIFO.
- detect_add  input  1  FSM in decoder_address.
- lfd_state  input  1  FSM in load_first_data.
- ld_state  input  1  FSM in load_data.
- full_state  input  1  FSM in fifo_full_state.
- laf_state  input  1  FSM in load_after_full.
- rst_int_reg  input  1  FSM in check_parity_error.
- dout  output  DATA_W  byte presented to output FIFO write port; written by FIFO when FSM write_enb_reg is high.
- parity_done  output  1  parity byte has been accepted.
- low_pkt_valid  output  1  end of payload seen (pkt_valid fell in load_data).
- err  output  1  parity mismatch flag for the last completed packet.

Behaviour:
- Reset (rst=1, asynchronous): dout, header_reg, hold_reg, int_parity and pkt_parity = 0; parity_done, low_pkt_valid and err = 0. All other updates are on posedge clk.
- One-cycle pipeline: a byte registered into dout at edge N is written by the FIFO at edge N+1, when the FSM asserts write_enb_reg.
- header_reg:
  - Loads data_in when detect_add && pkt_valid && data_in[ADDR_W-1:0] != 2'b11.
  - An address of 3 is never captured.
- dout priority, highest first:
  - lfd_state: dout <= header_reg.
  - ld_state && !fifo_full: dout <= data_in.
  - ld_state && fifo_full: hold_reg <= data_in; dout holds.
  - laf_state: dout <= hold_reg.
  - All other states, including full_state: dout holds.
- int_parity:
  - Cleared to 0 on detect_add.
  - lfd_state: int_parity ^= header_reg.
  - ld_state && pkt_valid: int_parity ^= data_in, regardless of fifo_full, because the byte is consumed either way.
  - Never updated in laf_state, which prevents double counting of the held byte.
- pkt_parity: loads data_in when ld_state && !pkt_valid, regardless of fifo_full.
- low_pkt_valid:
  - Set on ld_state && !pkt_valid.
  - Cleared on rst_int_reg or detect_add.
  - Set has priority over clear; the two never coincide in a legal FSM sequence.
- parity_done:
  - Set on ld_state && !pkt_valid && !fifo_full.
  - Also set on laf_state && low_pkt_valid && !parity_done; this covers the case where the parity byte landed in hold_reg.
  - Cleared on detect_add.
- err:
  - On the edge ending an rst_int_reg cycle: err <= (int_parity != pkt_parity).
  - Holds until the next header acceptance (detect_add && pkt_valid), where err <= 0.
- Boundaries:
  - fifo_full while the parity byte is on data_in: the byte goes to hold_reg, low_pkt_valid=1, parity_done=0 until laf_state.
  - Back-to-back packets: detect_add clears int_parity, parity_done and low_pkt_valid in the same cycle a new header is registered.
  - Reset mid-packet: all state returns to reset values immediately, with no partial parity retained.
  - Zero-length payload: the parity byte is simply the header value, and err=0 when parity == header.

Decomposition:
- router_pkg holds DATA_W, ADDR_W, the ADDR_INVALID = 2'b11 constant, and the FSM state encodings shared with the control FSM (3-bit, decoder_address=0 … load_after_full=7).
- One natural sub-module: router_parity_acc, containing int_parity, pkt_parity and err with clear/accumulate/compare enables.

Test Plan:
- Address 1, length 3:
  - Stimulus: header 8'h0D, payload 8'h11, 8'h22, 8'h33, parity 8'h0D.
  - Response: dout sequence 0D, 11, 22, 33, 0D; parity_done=1 after the parity byte; err=0 after rst_int_reg.
- Same packet with parity 8'hFF: err=1 the cycle after rst_int_reg; err returns to 0 on the next header acceptance.
- Same packet with fifo_full asserted in ld_state while data_in=8'h22:
  - hold_reg=8'h22; dout stays 8'h11 through full_state.
  - dout=8'h22 after laf_state.
  - Final err=0.
- fifo_full on the parity byte 8'h0D:
  - low_pkt_valid=1 and parity_done=0 in full_state.
  - parity_done=1 after laf_state; dout=8'h0D; err=0.
- Header 8'h07 (address 3) with detect_add && pkt_valid: header_reg is unchanged from its previous value (8'h0D).
- rst pulse mid-payload (after byte 8'h22): dout, parity_done, low_pkt_valid and err are all 0 asynchronously; the next clean packet yields err=0.
